p4_router_egress_sched: RTL and testbench

- Packet-atomic weighted round-robin scheduler that shares the single wide egress bus between NUM_INPUTS upstream queues, for example traffic classes or pipeline outputs.
- Output drives the egress demux bus of the P4 router egress subsystem. TUSER carries the egress port index and passes through untouched.
- Per-input weights and enables come from the register file. The block never splits a packet between inputs.

---
 rtl/p4_router_egress_sched.sv | 171 +++++++++++++++++
 tb/tb_p4_router_egress_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p4_router_egress_sched.sv
// Packet-atomic weighted round-robin scheduler sharing one AXIS egress bus between NUM_INPUTS queues.
// Optional per-input packet counters are compiled in when P4_ROUTER_EGR_SCHED_CNT_EN is defined.
`timescale 1ns/1ps
module p4_router_egress_sched #(
  parameter int NUM_INPUTS   = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int CNT_WIDTH    = 32,
  parameter int DATA_BYTES   = 8,
  parameter int USER_WIDTH   = 4,
  parameter int ID_WIDTH     = 4,
  parameter int DEST_WIDTH   = 4,
  localparam int IDX_W       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int DATA_W      = DATA_BYTES * 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_INPUTS-1:0][DATA_W-1:0]        axis_in_tdata,
  input  logic [NUM_INPUTS-1:0][DATA_BYTES-1:0]    axis_in_tkeep,
  input  logic [NUM_INPUTS-1:0][DATA_BYTES-1:0]    axis_in_tstrb,
  input  logic [NUM_INPUTS-1:0]                    axis_in_tlast,
  input  logic [NUM_INPUTS-1:0][ID_WIDTH-1:0]      axis_in_tid,
  input  logic [NUM_INPUTS-1:0][DEST_WIDTH-1:0]    axis_in_tdest,
  input  logic [NUM_INPUTS-1:0][USER_WIDTH-1:0]    axis_in_tuser,
  input  logic [NUM_INPUTS-1:0]                    axis_in_tvalid,
  output logic [NUM_INPUTS-1:0]                    axis_in_tready,
  output logic [DATA_W-1:0]                        axis_out_tdata,
  output logic [DATA_BYTES-1:0]                    axis_out_tkeep,
  output logic [DATA_BYTES-1:0]                    axis_out_tstrb,
  output logic                                     axis_out_tlast,
  output logic [ID_WIDTH-1:0]                      axis_out_tid,
  output logic [DEST_WIDTH-1:0]                    axis_out_tdest,
  output logic [USER_WIDTH-1:0]                    axis_out_tuser,
  output logic                                     axis_out_tvalid,
  input  logic                                     axis_out_tready,
  input  logic [NUM_INPUTS-1:0]                    in_enable,
  input  logic [NUM_INPUTS-1:0][WEIGHT_WIDTH-1:0]  weights,
  output logic [IDX_W-1:0]                         grant_idx,
  output logic                                     busy
`ifdef P4_ROUTER_EGR_SCHED_CNT_EN
  ,
  output logic [NUM_INPUTS-1:0][CNT_WIDTH-1:0]     pkt_cnt,
  input  logic [NUM_INPUTS-1:0]                    pkt_cnt_clear
`endif
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [IDX_W:0] NUM_W = (IDX_W + 1)'(NUM_INPUTS);

  state_t                                  state_q, state_d;
  logic [IDX_W-1:0]                        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]                        grant_q, grant_d;
  logic [NUM_INPUTS-1:0][WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [NUM_INPUTS-1:0]                   candidate, eligible;
  logic                                    any_elig;
  logic [IDX_W-1:0]                        pick;
  logic [IDX_W:0]                          idx_sum;
  logic                                    last_hs;

  // A zero weight still earns one packet per round; max(w,1) never exceeds 2^W-1.
  function automatic logic [WEIGHT_WIDTH-1:0] reload_val(input logic [WEIGHT_WIDTH-1:0] w);
    return (w == '0) ? WEIGHT_WIDTH'(1) : w;
  endfunction

  function automatic logic [WEIGHT_WIDTH-1:0] dec_floor(input logic [WEIGHT_WIDTH-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  always_comb begin
    candidate = axis_in_tvalid & in_enable;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      eligible[i] = candidate[i] & (credit_q[i] != '0);
    end
  end

  // First eligible input at or after rr_ptr, wrapping modulo NUM_INPUTS.
  always_comb begin
    any_elig = 1'b0;
    pick     = '0;
    idx_sum  = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
      if (idx_sum >= NUM_W) idx_sum = idx_sum - NUM_W;
      if (!any_elig && eligible[idx_sum[IDX_W-1:0]]) begin
        any_elig = 1'b1;
        pick     = idx_sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    axis_out_tdata  = axis_in_tdata[grant_q];
    axis_out_tkeep  = axis_in_tkeep[grant_q];
    axis_out_tstrb  = axis_in_tstrb[grant_q];
    axis_out_tlast  = axis_in_tlast[grant_q];
    axis_out_tid    = axis_in_tid[grant_q];
    axis_out_tdest  = axis_in_tdest[grant_q];
    axis_out_tuser  = axis_in_tuser[grant_q];
    axis_out_tvalid = (state_q == XFER) & axis_in_tvalid[grant_q];
    axis_in_tready  = '0;
    if (state_q == XFER) axis_in_tready[grant_q] = axis_out_tready;
  end

  assign last_hs   = axis_out_tvalid & axis_out_tready & axis_out_tlast;
  assign busy      = (state_q == XFER);
  assign grant_idx = grant_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    credit_d = credit_q;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          grant_d        = pick;
          credit_d[pick] = dec_floor(credit_q[pick]);
          rr_ptr_d       = (pick == IDX_W'(NUM_INPUTS - 1)) ? '0 : pick + 1'b1;
          state_d        = XFER;
        end else if (|candidate) begin
          // Round exhausted: refill every input, arbitration resumes next cycle.
          for (int i = 0; i < NUM_INPUTS; i++) begin
            credit_d[i] = reload_val(weights[i]);
          end
        end
      end
      XFER: begin
        if (last_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      credit_q <= credit_d;
    end
  end

`ifdef P4_ROUTER_EGR_SCHED_CNT_EN
  logic [NUM_INPUTS-1:0][CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

  // Clear has priority over a same-cycle tlast; counts stick at all-ones.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (pkt_cnt_clear[i]) begin
        pkt_cnt_d[i] = '0;
      end else if (last_hs && (grant_q == IDX_W'(i)) && (pkt_cnt_q[i] != '1)) begin
        pkt_cnt_d[i] = pkt_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pkt_cnt_q <= '0;
    else        pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_p4_router_egress_sched.sv
// Bench for p4_router_egress_sched: deterministic per-input packet sources, a cycle-level scheduling
// model with an in-order beat scoreboard, and directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_p4_router_egress_sched;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0][63:0] in_tdata;
  logic [N-1:0][7:0]  in_tkeep, in_tstrb;
  logic [N-1:0]       in_tlast, in_tvalid, in_tready;
  logic [N-1:0][3:0]  in_tid, in_tdest, in_tuser;
  logic [63:0]        out_tdata;
  logic [7:0]         out_tkeep, out_tstrb;
  logic               out_tlast, out_tvalid, out_tready;
  logic [3:0]         out_tid, out_tdest, out_tuser;
  logic [N-1:0]       in_enable;
  logic [N-1:0][7:0]  weights;
  logic [1:0]         grant_idx;
  logic               busy;
`ifdef P4_ROUTER_EGR_SCHED_CNT_EN
  logic [N-1:0][31:0] pkt_cnt;
  logic [N-1:0]       pkt_cnt_clear = '0;
  bit                 clr_arm = 0;
`endif

  p4_router_egress_sched dut (
    .clk(clk), .rst_n(rst_n),
    .axis_in_tdata(in_tdata), .axis_in_tkeep(in_tkeep), .axis_in_tstrb(in_tstrb),
    .axis_in_tlast(in_tlast), .axis_in_tid(in_tid), .axis_in_tdest(in_tdest),
    .axis_in_tuser(in_tuser), .axis_in_tvalid(in_tvalid), .axis_in_tready(in_tready),
    .axis_out_tdata(out_tdata), .axis_out_tkeep(out_tkeep), .axis_out_tstrb(out_tstrb),
    .axis_out_tlast(out_tlast), .axis_out_tid(out_tid), .axis_out_tdest(out_tdest),
    .axis_out_tuser(out_tuser), .axis_out_tvalid(out_tvalid), .axis_out_tready(out_tready),
    .in_enable(in_enable), .weights(weights), .grant_idx(grant_idx), .busy(busy)
`ifdef P4_ROUTER_EGR_SCHED_CNT_EN
    , .pkt_cnt(pkt_cnt), .pkt_cnt_clear(pkt_cnt_clear)
`endif
  );

  int n_chk = 0, n_fail = 0, cyc = 0;

  // Source state (what each upstream queue is presenting)
  int src_todo[N], src_seq[N], src_beat[N], fix_len[N];
  bit rand_len = 0, rand_rdy = 0;
  bit hs_in[N];

  // Model state
  bit m_busy;
  int m_grant, m_rr;
  int m_cred[N];
  int exp_seq[N], exp_beat[N], done_pkts[N];
  int glog[$];
  int slog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int plen(input int i, input int seq);
    if (rand_len) return 1 + ((i * 7 + seq * 3) % 4);
    return fix_len[i];
  endfunction

  function automatic logic [63:0] enc(input int i, input int seq, input int beat);
    return {8'hA5, 8'(i), 16'(seq), 16'(beat), 16'h5A00 ^ 16'(i)};
  endfunction

  function automatic logic [27:0] side(input int i, input int beat);
    return {8'h80 | 8'(i), 8'h40 | 8'(beat & 7), 4'(i), 4'(beat), 4'(i) ^ 4'hA};
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      in_tvalid[i] = (src_todo[i] > 0);
      in_tdata[i]  = enc(i, src_seq[i], src_beat[i]);
      in_tlast[i]  = (src_beat[i] == plen(i, src_seq[i]) - 1);
      {in_tkeep[i], in_tstrb[i], in_tid[i], in_tdest[i], in_tuser[i]} = side(i, src_beat[i]);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_grant = 0; m_rr = 0;
    for (int i = 0; i < N; i++) begin
      m_cred[i] = 0; exp_seq[i] = 0; exp_beat[i] = 0; hs_in[i] = 0;
    end
  endtask

  // One clock cycle of the scheduler's rules, evaluated on values the DUT will see at the next edge.
  task automatic model_step();
    bit was_busy;
    int g, pick;
    logic [N-1:0] exp_rdy;
    bit exp_last;
    was_busy = m_busy;
    chk("busy", busy, m_busy);
    chk("grant_idx", grant_idx, m_grant);
    if (!m_busy) begin
      chk("idle_tvalid", out_tvalid, 0);
      chk("idle_tready", in_tready, 0);
    end else begin
      g = m_grant;
      chk("out_tvalid", out_tvalid, in_tvalid[g]);
      exp_rdy = '0;
      exp_rdy[g] = out_tready;
      chk("in_tready", in_tready, exp_rdy);
      if (out_tvalid && out_tready) begin
        if (exp_beat[g] == 0) slog.push_back(cyc);
        exp_last = (exp_beat[g] == plen(g, exp_seq[g]) - 1);
        chk("tdata", out_tdata, enc(g, exp_seq[g], exp_beat[g]));
        chk("tlast", out_tlast, exp_last);
        chk("sideband", {out_tkeep, out_tstrb, out_tid, out_tdest, out_tuser}, side(g, exp_beat[g]));
        if (exp_last) begin
          exp_beat[g] = 0; exp_seq[g]++; done_pkts[g]++; m_busy = 0;
        end else begin
          exp_beat[g]++;
        end
      end
    end
    if (!was_busy) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (pick < 0 && in_tvalid[j] && in_enable[j] && m_cred[j] > 0) pick = j;
      end
      if (pick >= 0) begin
        m_cred[pick]--;
        m_rr = (pick + 1) % N;
        m_busy = 1;
        m_grant = pick;
        glog.push_back(pick);
      end else if (|(in_tvalid & in_enable)) begin
        for (int i = 0; i < N; i++) m_cred[i] = (weights[i] == 0) ? 1 : int'(weights[i]);
      end
    end
    for (int i = 0; i < N; i++) hs_in[i] = in_tvalid[i] && in_tready[i];
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) model_step();
      else model_reset();
`ifdef P4_ROUTER_EGR_SCHED_CNT_EN
      if (rst_n && clr_arm && out_tvalid && out_tready && out_tlast && grant_idx == 2'd1) begin
        pkt_cnt_clear[1] = 1'b1;
        clr_arm = 0;
      end
`endif
      @(posedge clk);
      #1;
`ifdef P4_ROUTER_EGR_SCHED_CNT_EN
      pkt_cnt_clear = '0;
`endif
      if (rst_n) begin
        for (int i = 0; i < N; i++) begin
          if (hs_in[i]) begin
            if (src_beat[i] == plen(i, src_seq[i]) - 1) begin
              src_beat[i] = 0; src_seq[i]++; src_todo[i]--;
            end else begin
              src_beat[i]++;
            end
            hs_in[i] = 0;
          end
        end
      end
      if (rand_rdy) out_tready = 1'($urandom_range(0, 1));
      drive_inputs();
    end
  end

  task automatic reset_assert_check();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_tvalid", out_tvalid, 0);
    chk("rst_tready", in_tready, 0);
`ifdef P4_ROUTER_EGR_SCHED_CNT_EN
    chk("rst_pkt_cnt", pkt_cnt, 0);
`endif
  endtask

  task automatic reset_finish();
    for (int i = 0; i < N; i++) begin
      src_todo[i] = 0; src_seq[i] = 0; src_beat[i] = 0; done_pkts[i] = 0;
    end
    rand_len = 0; rand_rdy = 0; out_tready = 1'b1;
    glog.delete(); slog.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset_assert_check();
    reset_finish();
  endtask

  function automatic bit any_todo();
    for (int i = 0; i < N; i++) if (src_todo[i] != 0) return 1;
    return 0;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int t;
    t = 0;
    while ((any_todo() || m_busy) && t < budget) begin
      @(posedge clk);
      t++;
    end
    #2;
    chk(name, t >= budget, 0);
  endtask

  task automatic wait_beat(input string name, input int i, input int beat, input int budget);
    int t;
    t = 0;
    while (exp_beat[i] != beat && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk(name, t >= budget, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2, t0;
    out_tready = 1'b1;
    in_enable = '1;
    for (int i = 0; i < N; i++) begin
      weights[i] = 8'd1; fix_len[i] = 2; src_todo[i] = 0; src_seq[i] = 0; src_beat[i] = 0;
    end
    drive_inputs();
    do_reset();

    // Equal weights, all inputs busy with 2-beat packets
    for (int i = 0; i < N; i++) src_todo[i] = 3;
    wait_idle("t1_drain", 400);
    chk("t1_nglog", glog.size(), 12);
    for (int k = 0; k < 8; k++) chk("t1_order", glog[k], k % 4);
    chk("t1_bubble", slog[1] - slog[0], 3);
    chk("t1_reload_gap", slog[4] - slog[3], 4);

    // Weights 3:1, inputs 0 and 1 only
    do_reset();
    weights[0] = 8'd3; weights[1] = 8'd1; weights[2] = 8'd0; weights[3] = 8'd0;
    fix_len[0] = 1; fix_len[1] = 1;
    src_todo[0] = 400; src_todo[1] = 400;
    t0 = 0;
    while (glog.size() < 400 && t0 < 3000) begin
      @(posedge clk);
      t0++;
    end
    #2;
    chk("t2_timeout", t0 >= 3000, 0);
    chk("t2_g0", glog[0], 0);
    chk("t2_g1", glog[1], 1);
    chk("t2_g2", glog[2], 0);
    chk("t2_g3", glog[3], 0);
    c0 = 0; c1 = 0;
    for (int k = 0; k < 400 && k < glog.size(); k++) begin
      if (glog[k] == 0) c0++;
      if (glog[k] == 1) c1++;
    end
    chk("t2_cnt0_in_range", (c0 >= 299 && c0 <= 301), 1);
    chk("t2_cnt1_in_range", (c1 >= 99 && c1 <= 101), 1);
    in_enable = '0;
    t0 = 0;
    while (m_busy && t0 < 50) begin
      @(posedge clk);
      t0++;
    end
    #2;
    for (int i = 0; i < N; i++) src_todo[i] = 0;
    in_enable = '1;

    // Disable input 2 in the middle of a 5-beat packet
    do_reset();
    for (int i = 0; i < N; i++) weights[i] = 8'd1;
    fix_len[2] = 5; fix_len[3] = 2;
    src_todo[2] = 3;
    wait_beat("t3_beat2", 2, 2, 100);
    @(posedge clk);
    #2;
    in_enable[2] = 1'b0;
    src_todo[3] = 2;
    repeat (40) @(posedge clk);
    #2;
    chk("t3_done2", done_pkts[2], 1);
    chk("t3_done3", done_pkts[3], 2);
    chk("t3_busy", busy, 0);
    chk("t3_tready2", in_tready[2], 0);
    c2 = 0;
    foreach (glog[k]) if (glog[k] == 2) c2++;
    chk("t3_grants2", c2, 1);
    src_todo[2] = 0;
    in_enable = '1;

    // Random backpressure with mixed packet lengths
    do_reset();
    weights[0] = 8'd2; weights[1] = 8'd1; weights[2] = 8'd3; weights[3] = 8'd1;
    rand_len = 1; rand_rdy = 1;
    for (int i = 0; i < N; i++) src_todo[i] = 8;
    wait_idle("t4_drain", 3000);
    for (int i = 0; i < N; i++) chk("t4_done", done_pkts[i], 8);
    rand_rdy = 0; rand_len = 0;
    out_tready = 1'b1;

    // Reset during beat 3 of a 6-beat packet
    do_reset();
    for (int i = 0; i < N; i++) weights[i] = 8'd1;
    fix_len[0] = 6;
    src_todo[0] = 1;
    wait_beat("t5_beat2", 0, 2, 100);
    #3;
    chk("t5_pre_rst_tvalid", out_tvalid, 1);
    reset_assert_check();
    reset_finish();
    fix_len[0] = 2; fix_len[1] = 2;
    src_todo[0] = 1; src_todo[1] = 1;
    t0 = cyc;
    wait_idle("t5_drain", 100);
    chk("t5_first_grant", glog[0], 0);
    chk("t5_first_latency", slog[0] - t0, 4);

`ifdef P4_ROUTER_EGR_SCHED_CNT_EN
    // Packet counter and clear-wins-over-increment
    do_reset();
    fix_len[1] = 2;
    src_todo[1] = 10;
    wait_idle("cnt_drain", 400);
    chk("pkt_cnt1_10", pkt_cnt[1], 10);
    chk("pkt_cnt0_0", pkt_cnt[0], 0);
    clr_arm = 1;
    src_todo[1] = 1;
    wait_idle("cnt_clr_drain", 100);
    chk("clr_armed_used", clr_arm, 0);
    chk("pkt_cnt1_clr", pkt_cnt[1], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
